// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the pointer counter family.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  // Binary to Gray for any width up to 32 bits (zero-extend narrower values).
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] r;
    r[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray encoder, the inverse of gray_to_binary.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_g
);

  // MSB passes straight through; every lower bit is the XOR of itself and its upper neighbour.
  assign o_g[WIDTH-1] = i_b[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign o_g[gi] = i_b[gi+1] ^ i_b[gi];
    end
  endgenerate

endmodule

// File: rtl/gray_pointer_counter.sv
// Up/down binary pointer with a coherent registered Gray copy, wrap pulse
// and a sticky single-bit-step checker.
module gray_pointer_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             wrap,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_g;
  logic             r_wrap;
  logic             r_step_err;

  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_g_next;
  logic             w_wrap_next;
  logic             w_step;
  logic             w_bad_step;

  // Exactly one of inc/dec means a real step; both together cancel out.
  assign w_step = (inc ^ dec) & ~load;

  // Next binary value and wrap detection, load taking priority over stepping.
  always_comb begin
    w_b_next    = r_b;
    w_wrap_next = 1'b0;
    if (load) begin
      w_b_next = D;
    end else if (inc && !dec) begin
      w_b_next    = r_b + ONE;
      w_wrap_next = (r_b == {WIDTH{1'b1}});
    end else if (dec && !inc) begin
      w_b_next    = r_b - ONE;
      w_wrap_next = (r_b == {WIDTH{1'b0}});
    end
  end

  // Gray is derived from next-B so both land in the same flop stage.
  binary_to_gray #(.WIDTH(WIDTH)) u_enc (
    .i_b (w_b_next),
    .o_g (w_g_next)
  );

  assign w_bad_step = w_step && ($countones(r_g ^ w_g_next) != 1);

  // Pointer, Gray copy, wrap pulse and sticky step flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b        <= '0;
      r_g        <= '0;
      r_wrap     <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_b    <= w_b_next;
      r_g    <= w_g_next;
      r_wrap <= w_wrap_next;
      if (w_bad_step) begin
        r_step_err <= 1'b1;
      end
    end
  end

  assign B        = r_b;
  assign G        = r_g;
  assign wrap     = r_wrap;
  assign step_err = r_step_err;

endmodule
